lcd_write_sequencer: RTL

- Sits downstream of the LSU output bank's LCD register; converts register writes into HD44780-compatible parallel bus write cycles with correct setup, enable-width, hold and execution-wait timing.
- Buffers back-to-back software writes in a small FIFO so the CPU can store faster than the panel can accept commands.
- Drives LCD pins and exposes busy/overflow status for readback through the input bank.

---
 rtl/lcd_write_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: buffers LCD register writes and replays them as timed HD44780 write cycles.
module lcd_write_sequencer #(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 20,
    parameter int T_PWRUP    = 750000,
    parameter int T_SETUP    = 4,
    parameter int T_EN       = 25,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2000,
    parameter int T_CLR_WAIT = 82000
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [31:0]              i_lcd_word,
    input  logic                     i_lcd_wr,
    output logic                     o_lcd_on,
    output logic                     o_lcd_rs,
    output logic                     o_lcd_rw,
    output logic                     o_lcd_en,
    output logic [7:0]               o_lcd_data,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [2:0] {S_PWRUP, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_WAIT} state_t;
    state_t           r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n, w_wait;
    logic [8:0]       r_mem [DEPTH];
    logic [8:0]       w_head;
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic             r_on, r_rs, r_en, r_clr, r_ovf;
    logic [7:0]       r_data;
    logic             w_pop, w_push, w_full, w_done, w_unused;

    assign w_unused = ^i_lcd_word[30:9];
    assign w_head   = r_mem[r_rptr];
    assign w_full   = r_count[AW];
    assign w_push   = i_lcd_wr && (!w_full || w_pop);
    assign w_done   = r_cnt <= CNT_W'(1);
    assign w_wait   = r_clr ? CNT_W'(T_CLR_WAIT) : CNT_W'(T_CMD_WAIT);

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= {i_lcd_word[8], i_lcd_word[7:0]};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_on    <= 1'b0;
        end else begin
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_ovf   <= r_ovf || (i_lcd_wr && !w_push);
            r_on    <= i_lcd_wr ? i_lcd_word[31] : r_on;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_PWRUP;
            r_cnt   <= CNT_W'(T_PWRUP);
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_done ? r_cnt : r_cnt - 1'b1;
        case (r_state)
            S_PWRUP: w_state_n = w_done ? S_IDLE : S_PWRUP;
            S_IDLE: begin
                w_state_n = w_pop ? S_SETUP : S_IDLE;
                w_cnt_n   = CNT_W'(T_SETUP);
            end
            S_SETUP: if (w_done) begin
                w_state_n = S_EN_HI;
                w_cnt_n   = CNT_W'(T_EN);
            end
            S_EN_HI: if (w_done) begin
                w_state_n = (T_HOLD == 0) ? S_WAIT : S_HOLD;
                w_cnt_n   = (T_HOLD == 0) ? w_wait : CNT_W'(T_HOLD);
            end
            S_HOLD: if (w_done) begin
                w_state_n = S_WAIT;
                w_cnt_n   = w_wait;
            end
            S_WAIT: w_state_n = w_done ? S_IDLE : S_WAIT;
            default: w_state_n = S_PWRUP;
        endcase
    end

    always_comb begin
        w_pop  = r_state == S_IDLE && r_count != '0;
        o_busy = r_state != S_IDLE || r_count != '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en   <= 1'b0;
            r_rs   <= 1'b0;
            r_data <= 8'h00;
            r_clr  <= 1'b0;
        end else begin
            r_en   <= w_state_n == S_EN_HI;
            r_rs   <= w_pop ? w_head[8] : r_rs;
            r_data <= w_pop ? w_head[7:0] : r_data;
            r_clr  <= w_pop ? (!w_head[8] && w_head[7:0] inside {8'h01, 8'h02, 8'h03}) : r_clr;
        end
    end

    assign o_lcd_on     = r_on;
    assign o_lcd_rs     = r_rs;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_en     = r_en;
    assign o_lcd_data   = r_data;
    assign o_fifo_count = r_count;
    assign o_overflow   = r_ovf;
endmodule
